// File: rtl/thr_pwm_ctrl.sv
// thr_pwm_ctrl: VIL/VIH threshold shadows, period-aligned apply and
// settle sequencing, and the registered PWM pair that drives the AFE.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cfg_wrt/sel/data    one-cycle write of a code to VIL (0) or VIH (1)
//   cfg_busy            write pending or settling
//   cfg_done            one-cycle pulse once every write is applied
//                       and has been held for a full period
//   thr_err, err_clr    sticky ordering error and its clear
//   vil_cur, vih_cur    codes currently driving the PWMs
//   VIL_PWM, VIH_PWM    registered PWM outputs to the AFE
//
// Optional: define THR_ORDER_CHK_EN to refuse any apply that would
// leave VIL >= VIH; thr_err then flags the dropped update. Without it
// codes apply unconditionally and thr_err is tied low.

module thr_pwm_ctrl #(
   parameter int         PER_BITS = 10,
   parameter logic [7:0] VIL_RST  = 8'h55,
   parameter logic [7:0] VIH_RST  = 8'hAA
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_wrt,
   input  logic       cfg_sel,
   input  logic [7:0] cfg_data,
   output logic       cfg_busy,
   output logic       cfg_done,
   output logic       thr_err,
   input  logic       err_clr,
   output logic [7:0] vil_cur,
   output logic [7:0] vih_cur,
   output logic       VIL_PWM,
   output logic       VIH_PWM
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t              state;
   logic [PER_BITS-1:0] per_cnt;
   logic [PER_BITS-1:0] per_nxt;
   logic                bnd;

   logic [7:0]          vil_shd;
   logic [7:0]          vih_shd;
   logic [1:0]          pend;
   logic [1:0]          pend_nxt;
   logic [1:0]          wr_mask;

   logic                apply;
   logic                ord_bad;
   logic                take;
   logic [7:0]          vil_cand;
   logic [7:0]          vih_cand;
   logic [7:0]          vil_nxt;
   logic [7:0]          vih_nxt;

   logic [PER_BITS:0]   cnt_ext;
   logic [PER_BITS:0]   vil_lim;
   logic [PER_BITS:0]   vih_lim;
   logic                vil_pwm_nxt;
   logic                vih_pwm_nxt;

   always_comb begin
      per_nxt  = per_cnt + 1'b1;
      bnd      = &per_cnt;

      // pend is the registered flag set, so a write landing on the
      // boundary cycle is not seen here and waits a full period
      apply    = bnd && (state != IDLE) && (|pend);

      vil_cand = pend[0] ? vil_shd : vil_cur;
      vih_cand = pend[1] ? vih_shd : vih_cur;

`ifdef THR_ORDER_CHK_EN
      ord_bad  = (vil_cand >= vih_cand);
`else
      ord_bad  = 1'b0;
`endif

      take     = apply && !ord_bad;
      vil_nxt  = take ? vil_cand : vil_cur;
      vih_nxt  = take ? vih_cand : vih_cur;

      // applying (or rejecting) consumes every pending flag; a write
      // in the same cycle re-arms its channel for the next boundary
      wr_mask  = {cfg_wrt & cfg_sel, cfg_wrt & ~cfg_sel};
      pend_nxt = (apply ? 2'b00 : pend) | wr_mask;

      // high while next count <= 4*code+1: 4*code+2 clocks per period,
      // so the AFE's cntr[9:2] lands exactly on the code
      cnt_ext  = {1'b0, per_nxt};
      vil_lim  = (PER_BITS+1)'({vil_nxt, 2'b01});
      vih_lim  = (PER_BITS+1)'({vih_nxt, 2'b01});

      vil_pwm_nxt = (vil_nxt != 8'd0) && (cnt_ext <= vil_lim);
      vih_pwm_nxt = (vih_nxt != 8'd0) && (cnt_ext <= vih_lim);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt  <= '0;
         vil_cur  <= VIL_RST;
         vih_cur  <= VIH_RST;
         vil_shd  <= 8'd0;
         vih_shd  <= 8'd0;
         pend     <= 2'b00;
         VIL_PWM  <= 1'b0;
         VIH_PWM  <= 1'b0;
         state    <= IDLE;
         cfg_busy <= 1'b0;
         cfg_done <= 1'b0;
      end else begin
         per_cnt  <= per_nxt;
         vil_cur  <= vil_nxt;
         vih_cur  <= vih_nxt;
         VIL_PWM  <= vil_pwm_nxt;
         VIH_PWM  <= vih_pwm_nxt;
         pend     <= pend_nxt;
         cfg_done <= 1'b0;

         if (wr_mask[0]) vil_shd <= cfg_data;
         if (wr_mask[1]) vih_shd <= cfg_data;

         unique case (state)
            IDLE: begin
               if (cfg_wrt || (|pend)) begin
                  state    <= PEND;
                  cfg_busy <= 1'b1;
               end else begin
                  cfg_busy <= 1'b0;
               end
            end
            PEND: begin
               cfg_busy <= 1'b1;
               if (bnd) state <= SETTLE;
            end
            SETTLE: begin
               cfg_busy <= 1'b1;
               if (bnd) begin
                  if (|pend) begin
                     state <= SETTLE;
                  end else if (cfg_wrt) begin
                     // write on the closing boundary: not done yet
                     state <= PEND;
                  end else begin
                     state    <= IDLE;
                     cfg_busy <= 1'b0;
                     cfg_done <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               cfg_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef THR_ORDER_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         thr_err <= 1'b0;
      end else if (apply && ord_bad) begin
         thr_err <= 1'b1;
      end else if (err_clr) begin
         thr_err <= 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign thr_err        = 1'b0;
`endif

endmodule

// File: tb/tb_thr_pwm_ctrl.sv
// tb_thr_pwm_ctrl: directed writes with hand-computed cycle, code and
// PWM high-time expectations, checked from queues by a monitor.

module tb_thr_pwm_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_wrt = 1'b0;
   logic       cfg_sel = 1'b0;
   logic [7:0] cfg_data = 8'd0;
   logic       err_clr = 1'b0;
   logic       cfg_busy;
   logic       cfg_done;
   logic       thr_err;
   logic [7:0] vil_cur;
   logic [7:0] vih_cur;
   logic       VIL_PWM;
   logic       VIH_PWM;

   thr_pwm_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_wrt  (cfg_wrt),
      .cfg_sel  (cfg_sel),
      .cfg_data (cfg_data),
      .cfg_busy (cfg_busy),
      .cfg_done (cfg_done),
      .thr_err  (thr_err),
      .err_clr  (err_clr),
      .vil_cur  (vil_cur),
      .vih_cur  (vih_cur),
      .VIL_PWM  (VIL_PWM),
      .VIH_PWM  (VIH_PWM)
   );

   always #5 clk = ~clk;

   // cycles since reset release; equals the DUT period count mod 1024
   int cyc;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cyc %0d)",
                  name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int    c;
      int    sel;
      int    val;
      string name;
   } probe_t;

   typedef struct {
      int per;
      int vil;
      int vih;
   } pw_t;

   probe_t pq[$];
   int     dq[$];
   pw_t    wq[$];

   task automatic probe(int c, int sel, int val, string name);
      probe_t p;
      int     i;
      p.c = c; p.sel = sel; p.val = val; p.name = name;
      i = 0;
      while (i < pq.size() && pq[i].c <= c) i++;
      pq.insert(i, p);
   endtask

   task automatic pwm_exp(int per, int vil, int vih);
      pw_t w;
      w.per = per; w.vil = vil; w.vih = vih;
      wq.push_back(w);
   endtask

   function automatic int sig(int sel);
      case (sel)
         0: return int'(vil_cur);
         1: return int'(vih_cur);
         2: return int'(cfg_busy);
         3: return int'(cfg_done);
         4: return int'(VIL_PWM);
         5: return int'(VIH_PWM);
         6: return int'(thr_err);
         default: return -1;
      endcase
   endfunction

   // monitor: all scoreboard comparisons happen here
   int hv = 0;
   int hh = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         hv = 0;
         hh = 0;
      end else begin
         while (pq.size() > 0 && pq[0].c < cyc) begin
            checks++; failures++;
            $display("FAIL %s: probe at cyc %0d not sampled",
                     pq[0].name, pq[0].c);
            void'(pq.pop_front());
         end
         while (pq.size() > 0 && pq[0].c == cyc) begin
            chk(pq[0].name, sig(pq[0].sel), pq[0].val);
            void'(pq.pop_front());
         end

         while (dq.size() > 0 && dq[0] < cyc) begin
            checks++; failures++;
            $display("FAIL done_missing: got none required pulse at cyc %0d",
                     dq[0]);
            void'(dq.pop_front());
         end
         if (cfg_done) begin
            checks++;
            if (dq.size() > 0 && dq[0] == cyc) begin
               void'(dq.pop_front());
            end else begin
               failures++;
               $display("FAIL done_unexpected: got pulse at cyc %0d required none",
                        cyc);
            end
         end

         hv += int'(VIL_PWM);
         hh += int'(VIH_PWM);
         if (cyc % 1024 == 1023) begin
            while (wq.size() > 0 && wq[0].per < cyc / 1024) begin
               checks++; failures++;
               $display("FAIL pwm_missing: period %0d not measured",
                        wq[0].per);
               void'(wq.pop_front());
            end
            if (wq.size() > 0 && wq[0].per == cyc / 1024) begin
               chk("vil_pwm_high", hv, wq[0].vil);
               chk("vih_pwm_high", hh, wq[0].vih);
               void'(wq.pop_front());
            end
            hv = 0;
            hh = 0;
         end
      end
   end

   task automatic wait_until(int t);
      while (cyc < t) @(negedge clk);
      if (cyc != t) begin
         checks++; failures++;
         $display("FAIL schedule: got cyc %0d required %0d", cyc, t);
      end
   endtask

   task automatic wr(int t, logic sel, logic [7:0] d);
      wait_until(t);
      cfg_sel  = sel;
      cfg_data = d;
      cfg_wrt  = 1'b1;
      @(negedge clk);
      cfg_wrt  = 1'b0;
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_vil"},  int'(vil_cur),  8'h55);
      chk({tag, "_vih"},  int'(vih_cur),  8'hAA);
      chk({tag, "_busy"}, int'(cfg_busy), 0);
      chk({tag, "_done"}, int'(cfg_done), 0);
      chk({tag, "_err"},  int'(thr_err),  0);
      chk({tag, "_vpwm"}, int'(VIL_PWM),  0);
      chk({tag, "_hpwm"}, int'(VIH_PWM),  0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      release_reset();

      // reset codes: 4*0x55+2 and 4*0xAA+2
      pwm_exp(1, 342, 682);

      // VIL=0x40 written at per_cnt 100 of period 2
      probe(2147, 2, 0,     "busy_before");
      probe(2149, 2, 1,     "busy_after_wr");
      probe(3071, 0, 8'h55, "vil_before_bnd");
      probe(3072, 0, 8'h40, "vil_at_bnd");
      probe(4095, 2, 1,     "busy_settle");
      probe(4096, 2, 0,     "busy_clear");
      dq.push_back(4096);
      pwm_exp(3, 258, 682);
      wr(2148, 1'b0, 8'h40);

      // two VIH writes in one period: last one wins, one done
      probe(5119, 1, 8'hAA, "vih_before_bnd");
      probe(5120, 1, 8'hD0, "vih_last_wins");
      dq.push_back(6144);
      pwm_exp(5, 258, 834);
      wr(4196, 1'b1, 8'hC0);
      wr(4296, 1'b1, 8'hD0);

      // code 0 keeps VIL_PWM low the whole period
      probe(7168, 0, 8'h00, "vil_zero");
      probe(7168, 4, 0,     "vpwm_zero_start");
      dq.push_back(8192);
      pwm_exp(7, 0, 834);
      wr(6194, 1'b0, 8'h00);

      // code 255: high 1022, low 2
      probe(10237, 4, 1, "vpwm_ff_last_hi");
      probe(10238, 4, 0, "vpwm_ff_lo0");
      probe(10239, 4, 0, "vpwm_ff_lo1");
      probe(10240, 4, 1, "vpwm_ff_rise");
      dq.push_back(10240);
      pwm_exp(9, 1022, 834);
      wr(8242, 1'b0, 8'hFF);

      // write on the per_cnt==1023 cycle waits one more period
      probe(11264, 1, 8'hD0, "vih_not_at_bnd");
      probe(11264, 2, 1,     "busy_bnd_wr");
      probe(12287, 1, 8'hD0, "vih_hold");
      probe(12288, 1, 8'h80, "vih_next_bnd");
      dq.push_back(13312);
      pwm_exp(12, 1022, 514);
      wr(11263, 1'b1, 8'h80);

      // write during SETTLE: applied at next boundary, one done
      probe(14336, 0, 8'h20, "vil_pend_apply");
      probe(15359, 1, 8'h80, "vih_settle_hold");
      probe(15360, 1, 8'h90, "vih_settle_apply");
      probe(15360, 3, 0,     "no_done_mid");
      dq.push_back(16384);
      pwm_exp(15, 130, 578);
      wr(13322, 1'b0, 8'h20);
      wr(14836, 1'b1, 8'h90);

      // VIL above VIH
`ifdef THR_ORDER_CHK_EN
      probe(17408, 0, 8'h20, "vil_order_kept");
      probe(17408, 1, 8'h90, "vih_order_kept");
      probe(17408, 6, 1,     "err_set");
      probe(18441, 6, 1,     "err_sticky");
`else
      probe(17408, 0, 8'hB0, "vil_no_chk");
      probe(17408, 6, 0,     "err_tied");
`endif
      probe(18443, 6, 0, "err_cleared");
      dq.push_back(18432);
      wr(16484, 1'b0, 8'hB0);
      wait_until(18442);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;

      // reset in SETTLE drops the done pulse
      probe(20480, 1, 8'hA0, "vih_pre_rst");
      wr(19556, 1'b1, 8'hA0);
      wait_until(20980);
      chk("queues_drained", pq.size() + dq.size() + wq.size(), 0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      repeat (3) @(negedge clk);
      release_reset();
      probe(1500, 2, 0,     "busy_after_rst");
      probe(1500, 1, 8'hAA, "vih_after_rst");
      pwm_exp(1, 342, 682);
      wait_until(2100);
      chk("queues_drained_end", pq.size() + dq.size() + wq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/thr_pwm_ctrl.md
Name: thr_pwm_ctrl

Overview:
Digital threshold controller that sets the AFE comparator thresholds for all five channels. It holds the VIL/VIH codes programmed by the capture logic or command path and produces the VIL_PWM/VIH_PWM duty-cycle signals that the AFE integrates over a 1024-clock period. It sequences threshold changes so a new code only takes effect at a PWM period boundary. It reports completion only after the AFE has had a full period to capture the new value.

Parameters:
PER_BITS, 10, PWM period counter width; period = 2^PER_BITS clocks (AFE captures high-count[9:2], so 10 is required for the AFE)
VIL_RST, 8'h55, VIL code after reset (matches AFE power-up 0.33)
VIH_RST, 8'hAA, VIH code after reset (matches AFE power-up 0.66)

Ports:
clk  input  1  system clock, same clock as the AFE smpl_clk
rst_n  input  1  asynchronous active-low reset
cfg_wrt  input  1  one-cycle write strobe
cfg_sel  input  1  0 = VIL, 1 = VIH
cfg_data  input  8  threshold code to write
cfg_busy  output  1  high while any write is pending or settling
cfg_done  output  1  one-cycle pulse when all writes are applied and settled
thr_err  output  1  sticky ordering error (only with THR_ORDER_CHK_EN; else tied 0)
err_clr  input  1  clears thr_err (ignored without the macro)
vil_cur  output  8  VIL code currently driving VIL_PWM
vih_cur  output  8  VIH code currently driving VIH_PWM
VIL_PWM  output  1  registered PWM to AFE VIL input
VIH_PWM  output  1  registered PWM to AFE VIH input

Behaviour:
- Reset (async, rst_n=0): per_cnt=0, vil_cur=VIL_RST, vih_cur=VIH_RST, shadows cleared, pend flags 0, state IDLE. VIL_PWM=VIH_PWM=0, cfg_busy=0, cfg_done=0, thr_err=0. Reset mid-operation discards any pending or settling write.
- per_cnt: free-running PER_BITS counter; wraps 1023->0. A boundary is the cycle with per_cnt==1023.
- PWM: X_PWM registered; next value = (X_cur!=0) && (per_cnt_next <= 4*X_cur+1). High time is exactly 4*code+2 clocks, which gives the AFE a 2-count margin so cntr[9:2]==code. code 0 -> constant low (no posedge, so the AFE keeps its previous value). code 255 -> high 1022, low 2. Both PWMs rise together at per_cnt 0.
- Write: cfg_wrt loads shadow[cfg_sel]=cfg_data and sets pend[cfg_sel]. Writes are accepted in every state. A repeat write to the same channel before the boundary overwrites the shadow (last write wins).
- FSM:
  - IDLE: cfg_busy=0. Any write -> PEND.
  - PEND: at the boundary, copy pending shadows to X_cur, clear pend -> SETTLE.
  - SETTLE: waits one full period so the AFE captures the new value on the PWM negedge. At the next boundary: if pend is set, apply it and stay in SETTLE; otherwise -> IDLE and pulse cfg_done for 1 cycle.
- cfg_busy = (state!=IDLE) || cfg_wrt registered; it rises the cycle after the write strobe.
- A write on the same cycle as a boundary is NOT applied at that boundary; it waits for the next one.
- X_cur changes only at a boundary, so the PWM never glitches mid-period.

Optional Feature:
THR_ORDER_CHK_EN:
- With the macro: at apply, if the resulting VIL >= VIH, neither channel updates. Pending values are dropped, thr_err is set (sticky until err_clr), and the FSM still goes to SETTLE then IDLE with cfg_done.
- Without the macro: values are applied unconditionally and thr_err is tied 0.

Test Plan:
- Reset release, no writes -> VIL_PWM high 342 clks/period, VIH_PWM high 682; AFE VIL=8'h55, VIH=8'hAA after the first negedge.
- Write VIL=8'h40 at per_cnt=100 -> busy the next cycle; vil_cur changes at the per_cnt 1023->0 boundary; VIL_PWM high 258 clks; cfg_done exactly 1024 clks after apply; AFE VIL==8'h40.
- Write VIH=8'hC0 then VIH=8'hD0 in the same period -> only 8'hD0 is applied; a single cfg_done pulse.
- Write VIL=8'h00 -> VIL_PWM stays low for the whole period; write 8'hFF -> high 1022, low 2; AFE VIL==8'hFF.
- Write on the exact per_cnt==1023 cycle -> applied one period later. Assert rst_n mid-SETTLE -> outputs return to reset values immediately, cfg_done never pulses.
- (THR_ORDER_CHK_EN) Write VIL=8'hB0 with VIH=8'hAA -> vil_cur stays 8'h55, thr_err=1 until err_clr, cfg_done still pulses.
